sram_fifo_ctrl: RTL and testbench
=================================

Name: sram_fifo_ctrl

Overview:
- Single-clock FIFO controller that turns the 16x32 1W1R SRAM macro (port 0 write, port 1 read) into a valid/ready streaming FIFO.
- It sits directly upstream of the macro: it drives the macro's write and read ports, and it captures the macro's read data into a 2-entry output buffer.
- The output buffer hides the macro's one-cycle read latency, so the FIFO sustains 1 word/cycle at both ports.
- Total capacity is 16 entries in the SRAM plus 2 in the output buffer.

Parameters:
DATA_WIDTH, 32, data word width (must match macro)
ADDR_WIDTH, 4, SRAM address width; SRAM depth = 2**ADDR_WIDTH = 16
OBUF_DEPTH, 2, output buffer entries (fixed; other values unsupported)

Ports:
clk  in  1  clock; the macro's clk0 and clk1 are tied to this same net
rst  in  1  asynchronous, active-high reset
in_valid  in  1  producer has a word
in_ready  out  1  FIFO accepts a word this cycle
in_data  in  32  write data
out_valid  out  1  out_data holds a valid word
out_ready  in  1  consumer takes the word
out_data  out  32  head-of-FIFO data, driven from a register
level  out  5  total words held: SRAM + in-flight + buffer, range 0..18
sram_csb0  out  1  macro port-0 chip select, active low
sram_addr0  out  4  macro write address
sram_din0  out  32  macro write data
sram_csb1  out  1  macro port-1 chip select, active low
sram_addr1  out  4  macro read address
sram_dout1  in  32  macro read data

Behaviour:
- Decided: one clock (clk); reset rst is asynchronous and active-high.
- State:
  - wptr[3:0] and rptr[3:0], both wrapping mod 16.
  - sram_cnt[4:0]: words written to the SRAM but not yet read-issued, range 0..16.
  - inflight: 1-bit flag, a read was issued last cycle.
  - ob_cnt: output buffer occupancy, 0..2, organised as head/tail registers.
- Reset (async, rst=1):
  - All pointers, counters and inflight clear to 0; out_valid=0; out_data=0; level=0.
  - in_ready=0 while rst=1.
  - sram_csb0 and sram_csb1 are forced to 1 combinationally while rst=1.
  - SRAM contents are logically discarded; a read in flight at reset is dropped and its data is never captured.
- Push:
  - in_ready = (sram_cnt != 16).
  - push = in_valid & in_ready.
  - On push: sram_csb0=0, sram_addr0=wptr, sram_din0=in_data, all driven combinationally (the macro registers them at the edge); wptr increments.
  - sram_csb0=1 otherwise.
- Read issue:
  - pop = out_valid & out_ready.
  - issue = (sram_cnt != 0) & ((ob_cnt + inflight - pop) < 2).
  - On issue: sram_csb1=0, sram_addr1=rptr; rptr increments.
  - The out_ready -> sram_csb1 combinational path is intended.
- sram_cnt next value = sram_cnt + push - issue.
- Capture: when inflight=1, sram_dout1 is written into the buffer at the next posedge.
  - Target is the head if the buffer is empty after the pop, otherwise the tail.
  - A pop shifts tail to head in the same edge.
- No read/write collision: issue requires sram_cnt>0, so rptr never equals wptr in a cycle where both ports are enabled.
- Latency:
  - Word accepted at edge E reaches out_valid=1 after edge E+2 (empty FIFO, out_ready=1).
  - Sustained throughput is 1 push and 1 pop per cycle.
- Timing requirement: clock half-period must exceed the macro's read DELAY.
- Boundary conditions:
  - Full, level=18: in_ready=0.
  - Full with a pop: in_ready stays 0 that cycle, because sram_cnt only drops on the next issue.
  - Empty: out_valid=0 and out_data holds its last value.
- Ordering: strict FIFO, including across pointer wrap.
- level = sram_cnt + inflight + ob_cnt, registered view updated every edge.

Test Plan:
- Reset, then push 0xA0000000..0xA0000011 with out_ready=0 -> in_ready drops after 18 accepts; level=18; sram_cnt=16.
- Empty FIFO, single push of 0xDEADBEEF at edge E -> out_valid rises after E+2 with out_data=0xDEADBEEF; level returns to 0 after the pop.
- Continuous push and pop of 40 incrementing words with in_valid=out_ready=1 -> after the initial 2-cycle fill, one word out per cycle, in order, across pointer wraps 15->0.
- Random out_ready pattern (about 50% duty) with continuous pushes -> no loss or duplication; level never exceeds 18; csb1 never low when sram_cnt=0.
- Same-cycle push and issue at sram_cnt=1..15 -> sram_addr0 != sram_addr1 in every such cycle; scoreboard matches.
- Assert rst mid-stream with level=10 and inflight=1 -> out_valid=0 and level=0 immediately; a new push of 0x12345678 emerges first; no stale data.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: streaming FIFO built on a 16x32 1W1R SRAM macro.
// Port 0 of the macro is the write port and port 1 is the read port; both are
// clocked by clk. A 2-entry output buffer absorbs the macro's one-cycle read
// latency, so the FIFO sustains one push and one pop per cycle.
//
// Handshake: a word moves on an interface at a rising clk edge exactly when
// valid and ready are both 1 in the cycle before that edge. A producer must keep
// in_valid and in_data stable until in_ready is seen. out_valid and out_data are
// held until out_ready is seen. in_ready does not depend on in_valid. out_valid
// does not depend on out_ready.
module sram_fifo_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int OBUF_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  sram_csb0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);

   // SRAM depth as a count value (2**ADDR_WIDTH), one bit wider than a pointer.
   localparam logic [ADDR_WIDTH:0] SRAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
   // Output buffer slots that reads may be issued into.
   localparam logic [2:0]          OB_LIMIT   = 3'(OBUF_DEPTH);

   // SRAM-side bookkeeping.
   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [ADDR_WIDTH:0]   sram_cnt;
   logic [ADDR_WIDTH:0]   sram_cnt_nxt;
   logic                  inflight;

   // Output buffer: ob_head is the word presented on out_data, ob_tail the next.
   logic [1:0]            ob_cnt;
   logic [1:0]            ob_after_pop;
   logic [1:0]            ob_cnt_nxt;
   logic [DATA_WIDTH-1:0] ob_head;
   logic [DATA_WIDTH-1:0] ob_tail;

   // Handshake events of the current cycle.
   logic                  push;
   logic                  pop;
   logic                  issue;
   logic [2:0]            ob_occ_after;
   logic [ADDR_WIDTH:0]   level_nxt;

   // Handshakes, read-issue decision and the combinational macro port drive.
   always_comb begin
      in_ready     = 1'b0;
      push         = 1'b0;
      out_valid    = 1'b0;
      pop          = 1'b0;
      ob_occ_after = 3'd0;
      issue        = 1'b0;
      sram_csb0    = 1'b1;
      sram_addr0   = wptr;
      sram_din0    = in_data;
      sram_csb1    = 1'b1;
      sram_addr1   = rptr;

      // Space is judged on the SRAM alone; the buffer is fed only by reads.
      in_ready  = ~rst & (sram_cnt != SRAM_DEPTH);
      push      = in_valid & in_ready;
      out_valid = (ob_cnt != 2'd0);
      pop       = out_valid & out_ready;

      // Buffer slots that will be taken once this cycle's pop and the read in
      // flight have landed; a new read is issued only if one slot stays free.
      // Using pop here makes out_ready reach sram_csb1 combinationally, which
      // is what keeps the read stream going at full rate.
      ob_occ_after = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
      issue        = ~rst & (sram_cnt != '0) & (ob_occ_after < OB_LIMIT);

      // The macro registers chip select, address and data at the next edge.
      // A read is only issued for a word written at an earlier edge, so the
      // read and write addresses never match while both ports are enabled.
      sram_csb0 = ~push;
      sram_csb1 = ~issue;
   end

   // Next-state arithmetic shared by the counters and the level view.
   always_comb begin
      sram_cnt_nxt = sram_cnt;
      ob_after_pop = ob_cnt;
      ob_cnt_nxt   = ob_cnt;
      level_nxt    = level;

      sram_cnt_nxt = sram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
      ob_after_pop = ob_cnt - {1'b0, pop};
      ob_cnt_nxt   = ob_after_pop + {1'b0, inflight};
      level_nxt    = sram_cnt_nxt + (ADDR_WIDTH+1)'(issue) + (ADDR_WIDTH+1)'(ob_cnt_nxt);
   end

   // SRAM pointers, SRAM occupancy and the read-in-flight flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         sram_cnt <= '0;
         inflight <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (issue) begin
            rptr <= rptr + 1'b1;
         end
         sram_cnt <= sram_cnt_nxt;
         inflight <= issue;
      end
   end

   // Output buffer: pop shifts tail to head, returning read data fills the
   // first slot that is free after the pop. Reset drops any read in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ob_cnt  <= 2'd0;
         ob_head <= '0;
         ob_tail <= '0;
      end else begin
         if (pop && (ob_cnt == 2'd2)) begin
            ob_head <= ob_tail;
         end
         if (inflight) begin
            if (ob_after_pop == 2'd0) begin
               ob_head <= sram_dout1;
            end else begin
               ob_tail <= sram_dout1;
            end
         end
         ob_cnt <= ob_cnt_nxt;
      end
   end

   // Registered total occupancy: SRAM words, the read in flight and the buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= '0;
      end else begin
         level <= level_nxt;
      end
   end

   assign out_data = ob_head;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed bench for sram_fifo_ctrl with a behavioural
// model of the 16x32 1W1R SRAM macro and an in-order scoreboard.
module tb_sram_fifo_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  level;
   logic        sram_csb0;
   logic [3:0]  sram_addr0;
   logic [31:0] sram_din0;
   logic        sram_csb1;
   logic [3:0]  sram_addr1;
   logic [31:0] sram_dout1;

   logic [31:0] mem [16];
   logic [31:0] exp_q [$];

   int n_cmp;
   int n_err;
   int cyc;
   int m_cnt;
   int n_pop;
   int first_pop;
   int last_pop;
   bit pushed;
   int acc;

   sram_fifo_ctrl #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(4),
      .OBUF_DEPTH(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .sram_csb0 (sram_csb0),
      .sram_addr0(sram_addr0),
      .sram_din0 (sram_din0),
      .sram_csb1 (sram_csb1),
      .sram_addr1(sram_addr1),
      .sram_dout1(sram_dout1)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Macro model: write and read requests registered at the edge, read data
   // presented during the following cycle.
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      sram_dout1 = 32'h0;
   end

   always @(posedge clk) begin
      if (!sram_csb0) mem[sram_addr0] <= sram_din0;
      if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: sample at negedge, score handshakes, then step to
   // just after the next posedge where new inputs can be driven.
   task automatic cycle();
      @(negedge clk);
      check("level", 32'(level), 32'(exp_q.size()));
      check("in_ready", 32'(in_ready), 32'(m_cnt != 16));
      if (!sram_csb1) check("rd_nonempty", 32'(m_cnt > 0), 32'd1);
      if (!sram_csb0 && !sram_csb1) check("addr_clash", 32'(sram_addr0 != sram_addr1), 32'd1);
      if (out_valid && out_ready) begin
         check("pop_has_exp", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("pop_data", out_data, exp_q.pop_front());
         n_pop++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
      pushed = in_valid && in_ready;
      if (pushed) exp_q.push_back(in_data);
      m_cnt = m_cnt + (!sram_csb0 ? 1 : 0) - (!sram_csb1 ? 1 : 0);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int limit);
      for (int k = 0; k < limit && (exp_q.size() != 0 || out_valid); k++) cycle();
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      cyc       = 0;
      m_cnt     = 0;
      n_pop     = 0;
      first_pop = -1;
      last_pop  = -1;
      pushed    = 0;
      acc       = 0;
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hFFFF_FFFF;
      out_ready = 1'b1;

      // Reset state, with a producer already offering a word.
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_csb0", 32'(sram_csb0), 32'd1);
      check("rst_csb1", 32'(sram_csb1), 32'd1);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Fill to capacity with the consumer stalled.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 30; i++) begin
         in_data = 32'hA000_0000 + 32'(acc);
         cycle();
         if (pushed) acc++;
      end
      check("fill_accepts", 32'(acc), 32'd18);
      check("fill_level", 32'(level), 32'd18);
      check("fill_in_ready", 32'(in_ready), 32'd0);

      // Full with a pop: still not ready this cycle.
      out_ready = 1'b1;
      in_data   = 32'hBAD0_0000;
      check("full_pop_in_ready", 32'(in_ready), 32'd0);
      cycle();
      check("full_pop_no_push", 32'(pushed), 32'd0);
      in_valid = 1'b0;
      drain(60);
      check("empty_out_valid", 32'(out_valid), 32'd0);
      check("empty_hold", out_data, 32'hA000_0011);
      check("empty_level", 32'(level), 32'd0);

      // Single word latency through an empty FIFO.
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      cycle();
      in_valid = 1'b0;
      check("lat_e0_valid", 32'(out_valid), 32'd0);
      check("lat_e0_level", 32'(level), 32'd1);
      cycle();
      check("lat_e1_valid", 32'(out_valid), 32'd0);
      cycle();
      check("lat_e2_valid", 32'(out_valid), 32'd1);
      check("lat_e2_data", out_data, 32'hDEAD_BEEF);
      cycle();
      check("lat_pop_valid", 32'(out_valid), 32'd0);
      check("lat_pop_level", 32'(level), 32'd0);

      // Continuous streaming of 40 words across pointer wraps.
      n_pop     = 0;
      first_pop = -1;
      cyc       = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in_data = 32'h5000_0000 + 32'(i);
         cycle();
         check("stream_accept", 32'(pushed), 32'd1);
      end
      in_valid = 1'b0;
      drain(20);
      check("stream_pops", 32'(n_pop), 32'd40);
      check("stream_first", 32'(first_pop), 32'd3);
      check("stream_span", 32'(last_pop - first_pop), 32'd39);

      // Continuous pushes against a random consumer.
      for (int i = 0; i < 200; i++) begin
         in_valid  = 1'b1;
         in_data   = $urandom;
         out_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      // Random producer and consumer, exercising many SRAM fill levels.
      for (int i = 0; i < 200; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         out_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain(100);

      // Reset mid-stream with level 10 and a read in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 11; i++) begin
         in_data = 32'hC000_0000 + 32'(i);
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      check("mid_level", 32'(level), 32'd10);
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_level", 32'(level), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_csb1", 32'(sram_csb1), 32'd1);
      exp_q.delete();
      m_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      cycle();
      in_valid = 1'b0;
      for (int k = 0; k < 5 && !out_valid; k++) cycle();
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_data", out_data, 32'h1234_5678);
      check("post_rst_level", 32'(level), 32'd1);
      out_ready = 1'b1;
      drain(10);
      check("post_rst_final_level", 32'(level), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
